sr165_scan_reader: RTL
======================

Name: sr165_scan_reader

Overview:
- FPGA-side master that scans a daisy-chain of '165 parallel-in/serial-out shift registers (the discrete limit/alarm inputs board).
- Generates load_n and sclk, samples the chain's serial output sdi, and assembles an N-bit word.
- Applies a two-scan consistency filter and presents stable input bits plus strobes to the register/control logic downstream.

Parameters:
- N, 16, chain length in bits (8 per chip; 16 = 2 chips, 32 = 4 chips); N >= 2.
- HALF_DIV, 4, clk cycles per sclk half-period and per load_n low pulse; HALF_DIV >= 4.
- GAP, 8, idle clk cycles between the end of one scan and the next load; GAP >= 0.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active low
- enable  input  1  run continuous scanning while high
- load_n  output  1  chain parallel load, active low
- sclk  output  1  chain shift clock, idle low
- sdi  input  1  serial data from chain (MSB of last chip first), asynchronous to clk
- raw  output  N  last completed scan, unfiltered
- data  output  N  filtered stable inputs
- valid  output  1  one-clk strobe per completed scan
- changed  output  1  one-clk strobe when data takes a new value
- busy  output  1  high from LOAD entry through the end of the DONE cycle

Behaviour:
- Reset (async, rst_n low): load_n=1, sclk=0, raw=0, data=0, valid=0, changed=0, busy=0, FSM=IDLE, counters=0, filter history cleared.
- sdi passes through a 2-FF synchronizer (sdi_s) before use.
- FSM states: IDLE, LOAD, LOW, HIGH, DONE, WAIT.
- IDLE: outputs at reset values. On enable=1, go to LOAD next cycle.
- LOAD: load_n=0 for HALF_DIV cycles, then LOW.
- LOW: sclk=0 for HALF_DIV cycles. On the last cycle: shift <= {shift[N-2:0], sdi_s} and bit_cnt++. If bit_cnt reaches N, go to DONE; otherwise go to HIGH.
- HIGH: sclk=1 for HALF_DIV cycles, then LOW. The chain shifts on the sclk rising edge.
- Bit order and edge count: first bit sampled = chain data[N-1]. Exactly N-1 sclk rising edges per scan. Scan length from LOAD entry to DONE = 2*N*HALF_DIV cycles.
- DONE, single cycle; registered updates visible the following cycle, coincident with valid=1:
  - raw <= shift.
  - If a previous scan exists, shift == previous raw, and shift != data: data <= shift and changed=1.
  - First scan after reset or re-enable only records history; data is not updated.
- WAIT: GAP cycles. Then go to LOAD if enable=1, else IDLE. With GAP=0, go directly from DONE.
- Scan period in continuous mode = 2*N*HALF_DIV + 1 + GAP cycles.
- enable deasserted mid-scan: the current scan completes normally (valid pulses), then the FSM returns to IDLE. Filter history is cleared when entering IDLE.
- enable reasserted in WAIT: no effect until WAIT ends.
- Reset mid-scan: outputs drop to reset values immediately. The partial word is discarded and never reported.
- valid and changed are never high for more than one cycle. changed is only ever high in a cycle where valid is high.
- load_n and sclk are never active simultaneously. sclk=0 throughout LOAD.

Test Plan:
- Two-chip model, N=16, HALF_DIV=4, GAP=8, chain inputs 16'hA55A, enable=1 after reset:
  - load_n low 4 clks, 15 sclk rising edges per scan.
  - First valid: raw=A55A, data=0000, changed=0.
  - Second valid, 137 clks later: data=A55A, changed=1.
  - Third valid: changed=0.
- Glitch filtering: chain inputs forced to 16'h0001 for exactly one scan, then back to A55A. Response: raw=0001 for that one valid, data stays A55A, no changed pulse.
- Disable mid-scan: enable=0 during bit 5. The scan finishes with raw=current inputs and one valid pulse, busy falls, then load_n=1 and sclk=0 with no further activity.
- Reset mid-scan: rst_n low during HIGH phase of bit 9. Same cycle: load_n=1, sclk=0, data=0, raw=0. After release with enable=1, data updates only at the second full valid.
- Four-chip model, N=32, inputs 32'h8000_0001, two scans. Response: data=32'h8000_0001 (MSB/LSB order), 31 rising edges per scan.
- Timing check, N=16 defaults: every sclk high and low pulse exactly 4 clks, load_n low exactly 4 clks, valid-to-valid spacing exactly 137 clks, changed only when valid=1.

Source files
------------

// File: rtl/sr165_scan_reader_if.sv
// Bundles the '165 chain pins and the scan-result bus between the reader and its users.
// The master modport belongs to the reader; the slave side is the chain plus downstream logic.
interface sr165_scan_reader_if #(
    parameter int N = 16
);
    logic         enable;
    logic         load_n;
    logic         sclk;
    logic         sdi;
    logic [N-1:0] raw;
    logic [N-1:0] data;
    logic         valid;
    logic         changed;
    logic         busy;

    modport master (
        input  enable, sdi,
        output load_n, sclk, raw, data, valid, changed, busy
    );

    modport slave (
        output enable, sdi,
        input  load_n, sclk, raw, data, valid, changed, busy
    );
endinterface

// File: rtl/sr165_scan_reader.sv
// Scans a daisy chain of '165 PISO registers, assembles an N-bit word per scan and
// publishes it only once two consecutive scans agree.
module sr165_scan_reader #(
    parameter int N        = 16,
    parameter int HALF_DIV = 4,
    parameter int GAP      = 8
) (
    input logic                clk,
    input logic                rst_n,
    sr165_scan_reader_if.master bus
);
    localparam int DW = $clog2(HALF_DIV);
    localparam int BW = $clog2(N + 1);
    localparam int GW = $clog2(GAP + 1) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE, WAIT} state_t;

    state_t         state, state_nx;
    logic [DW-1:0]  div_cnt;
    logic [BW-1:0]  bit_cnt;
    logic [GW-1:0]  gap_cnt;
    logic           sdi_meta, sdi_s;
    logic [N-1:0]   shift;
    logic [N-1:0]   raw_q, data_q;
    logic           have_prev;
    logic           load_n_q, sclk_q, valid_q, changed_q, busy_q;
    logic           div_last, gap_last, accept;

    assign div_last = (div_cnt == DIV_LAST);
    assign gap_last = (gap_cnt == GAP_LAST);
    // A word is published only when it repeats the previous scan and differs from what is shown.
    assign accept   = have_prev && (shift == raw_q) && (shift != data_q);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.enable) state_nx = LOAD;
            LOAD: if (div_last) state_nx = LOW;
            LOW:  if (div_last) state_nx = (bit_cnt == BIT_LAST) ? DONE : HIGH;
            HIGH: if (div_last) state_nx = LOW;
            DONE: begin
                if (GAP > 0) state_nx = WAIT;
                else         state_nx = bus.enable ? LOAD : IDLE;
            end
            WAIT: if (gap_last) state_nx = bus.enable ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            sdi_meta  <= 1'b0;
            sdi_s     <= 1'b0;
            shift     <= '0;
            raw_q     <= '0;
            data_q    <= '0;
            have_prev <= 1'b0;
            load_n_q  <= 1'b1;
            sclk_q    <= 1'b0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            sdi_meta <= bus.sdi;
            sdi_s    <= sdi_meta;

            if ((state == LOAD || state == LOW || state == HIGH) && !div_last)
                div_cnt <= div_cnt + 1'b1;
            else
                div_cnt <= '0;

            if (state == WAIT && state_nx == WAIT)
                gap_cnt <= gap_cnt + 1'b1;
            else
                gap_cnt <= '0;

            if (state_nx == LOAD && state != LOAD) begin
                bit_cnt <= '0;
            end else if (state == LOW && div_last) begin
                bit_cnt <= bit_cnt + 1'b1;
                shift   <= {shift[N-2:0], sdi_s};
            end

            // Result registers update in DONE so they appear together with valid.
            valid_q   <= (state == DONE);
            changed_q <= (state == DONE) && accept;
            if (state == DONE) begin
                raw_q <= shift;
                if (accept) data_q <= shift;
            end

            if (state_nx == IDLE)  have_prev <= 1'b0;
            else if (state == DONE) have_prev <= 1'b1;

            // Pin drives follow the next state so they line up exactly with each phase.
            load_n_q <= (state_nx != LOAD);
            sclk_q   <= (state_nx == HIGH);
            busy_q   <= (state_nx == LOAD) || (state_nx == LOW) ||
                        (state_nx == HIGH) || (state_nx == DONE);
        end
    end

    assign bus.load_n  = load_n_q;
    assign bus.sclk    = sclk_q;
    assign bus.raw     = raw_q;
    assign bus.data    = data_q;
    assign bus.valid   = valid_q;
    assign bus.changed = changed_q;
    assign bus.busy    = busy_q;
endmodule
